// File: rtl/yukle_kaydet_birimi_if.sv
// Request, result and data-memory signals of the load/store unit.
// A request transfers on a rising edge where istek_gecerli && istek_hazir; request fields need only be valid then.
interface yukle_kaydet_birimi_if;
    logic        istek_gecerli;
    logic        istek_hazir;
    logic        istek_yaz;
    logic [2:0]  funct3;
    logic [31:0] adres;
    logic [31:0] kaydet_veri;
    logic        sonuc_gecerli;
    logic [31:0] sonuc_veri;
    logic        hizasiz_hata;
    logic        bellek_oku_aktif;
    logic        bellek_yaz_aktif;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_yaz_veri;
    logic [31:0] bellek_oku_veri;

    modport slave (
        input  istek_gecerli, istek_yaz, funct3, adres, kaydet_veri, bellek_oku_veri,
        output istek_hazir, sonuc_gecerli, sonuc_veri, hizasiz_hata,
               bellek_oku_aktif, bellek_yaz_aktif, bellek_adres, bellek_yaz_veri
    );

    modport master (
        output istek_gecerli, istek_yaz, funct3, adres, kaydet_veri, bellek_oku_veri,
        input  istek_hazir, sonuc_gecerli, sonuc_veri, hizasiz_hata,
               bellek_oku_aktif, bellek_yaz_aktif, bellek_adres, bellek_yaz_veri
    );
endinterface

// File: rtl/yukle_kaydet_birimi.sv
// RV32I load/store unit in front of a word-only data memory.
// Sub-word stores are a read-modify-write; loads extract and sign/zero extend.
module yukle_kaydet_birimi (
    input  logic                        clk,
    input  logic                        rst,
    yukle_kaydet_birimi_if.slave        yk,
    output logic [1:0]                  o_durum
);
    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        OKU     = 2'd1,
        RMW_OKU = 2'd2,
        YAZ     = 2'd3
    } durum_t;

    durum_t      r_durum;
    durum_t      w_sonraki;
    logic [1:0]  r_bayt_konum;
    logic [2:0]  r_funct3;
    logic [15:0] r_kaydet_alt;
    logic [31:0] r_birlesik;
    logic [31:0] r_bellek_adres;
    logic [31:0] r_sonuc_veri;
    logic        r_sonuc_gecerli;
    logic        r_hizasiz_hata;

    logic        w_kabul;
    logic        w_funct3_gecerli;
    logic        w_hizasiz;
    logic        w_yasadisi;
    logic [7:0]  w_bayt;
    logic [15:0] w_yarim;
    logic [31:0] w_yukle_sonuc;
    logic [31:0] w_birlesik;

    assign w_kabul = yk.istek_gecerli && (r_durum == BOSTA);

    always_comb begin
        w_funct3_gecerli = 1'b0;
        case (yk.funct3)
            3'b000, 3'b001, 3'b010: w_funct3_gecerli = 1'b1;
            3'b100, 3'b101:         w_funct3_gecerli = !yk.istek_yaz;
            default:                w_funct3_gecerli = 1'b0;
        endcase
    end

    always_comb begin
        w_hizasiz = 1'b0;
        case (yk.funct3[1:0])
            2'b01:   w_hizasiz = yk.adres[0];
            2'b10:   w_hizasiz = (yk.adres[1:0] != 2'b00);
            default: w_hizasiz = 1'b0;
        endcase
    end

    assign w_yasadisi = !w_funct3_gecerli || w_hizasiz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOSTA: begin
                if (w_kabul && !w_yasadisi) begin
                    if (!yk.istek_yaz)                w_sonraki = OKU;
                    else if (yk.funct3[1:0] == 2'b10) w_sonraki = YAZ;
                    else                              w_sonraki = RMW_OKU;
                end
            end
            OKU:     w_sonraki = BOSTA;
            RMW_OKU: w_sonraki = YAZ;
            YAZ:     w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    // Lane selection works on the word the memory returned this cycle.
    always_comb begin
        w_bayt = yk.bellek_oku_veri[7:0];
        case (r_bayt_konum)
            2'd0: w_bayt = yk.bellek_oku_veri[7:0];
            2'd1: w_bayt = yk.bellek_oku_veri[15:8];
            2'd2: w_bayt = yk.bellek_oku_veri[23:16];
            2'd3: w_bayt = yk.bellek_oku_veri[31:24];
            default: w_bayt = yk.bellek_oku_veri[7:0];
        endcase
        w_yarim = r_bayt_konum[1] ? yk.bellek_oku_veri[31:16] : yk.bellek_oku_veri[15:0];
    end

    always_comb begin
        w_yukle_sonuc = yk.bellek_oku_veri;
        case (r_funct3)
            3'b000:  w_yukle_sonuc = {{24{w_bayt[7]}}, w_bayt};
            3'b001:  w_yukle_sonuc = {{16{w_yarim[15]}}, w_yarim};
            3'b100:  w_yukle_sonuc = {24'h0, w_bayt};
            3'b101:  w_yukle_sonuc = {16'h0, w_yarim};
            default: w_yukle_sonuc = yk.bellek_oku_veri;
        endcase
    end

    always_comb begin
        w_birlesik = yk.bellek_oku_veri;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_bayt_konum)
                2'd0: w_birlesik[7:0]   = r_kaydet_alt[7:0];
                2'd1: w_birlesik[15:8]  = r_kaydet_alt[7:0];
                2'd2: w_birlesik[23:16] = r_kaydet_alt[7:0];
                2'd3: w_birlesik[31:24] = r_kaydet_alt[7:0];
                default: w_birlesik = yk.bellek_oku_veri;
            endcase
        end else if (r_bayt_konum[1]) begin
            w_birlesik[31:16] = r_kaydet_alt;
        end else begin
            w_birlesik[15:0] = r_kaydet_alt;
        end
    end

    // Result pulses and sonuc_veri last exactly one cycle; sonuc_veri is 0 unless a load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bayt_konum    <= 2'd0;
            r_funct3        <= 3'd0;
            r_kaydet_alt    <= 16'h0;
            r_birlesik      <= 32'h0;
            r_bellek_adres  <= 32'h0;
            r_sonuc_veri    <= 32'h0;
            r_sonuc_gecerli <= 1'b0;
            r_hizasiz_hata  <= 1'b0;
        end else begin
            r_sonuc_gecerli <= 1'b0;
            r_hizasiz_hata  <= 1'b0;
            r_sonuc_veri    <= 32'h0;
            case (r_durum)
                BOSTA: begin
                    if (w_kabul) begin
                        if (w_yasadisi) begin
                            r_sonuc_gecerli <= 1'b1;
                            r_hizasiz_hata  <= 1'b1;
                        end else begin
                            r_bayt_konum   <= yk.adres[1:0];
                            r_funct3       <= yk.funct3;
                            r_kaydet_alt   <= yk.kaydet_veri[15:0];
                            r_birlesik     <= yk.kaydet_veri;
                            r_bellek_adres <= {yk.adres[31:2], 2'b00};
                        end
                    end
                end
                OKU: begin
                    r_sonuc_gecerli <= 1'b1;
                    r_sonuc_veri    <= w_yukle_sonuc;
                end
                RMW_OKU: r_birlesik <= w_birlesik;
                YAZ:     r_sonuc_gecerli <= 1'b1;
                default: r_sonuc_gecerli <= 1'b0;
            endcase
        end
    end

    assign yk.istek_hazir      = (r_durum == BOSTA);
    assign yk.bellek_oku_aktif = (r_durum == OKU) || (r_durum == RMW_OKU);
    assign yk.bellek_yaz_aktif = (r_durum == YAZ);
    assign yk.bellek_yaz_veri  = (r_durum == YAZ) ? r_birlesik : 32'h0;
    assign yk.bellek_adres     = r_bellek_adres;
    assign yk.sonuc_gecerli    = r_sonuc_gecerli;
    assign yk.sonuc_veri       = r_sonuc_veri;
    assign yk.hizasiz_hata     = r_hizasiz_hata;
    assign o_durum             = r_durum;
endmodule

// File: tb/tb_yukle_kaydet_birimi.sv
// Bench for yukle_kaydet_birimi: directed scenarios plus random requests against a byte-array model.
module tb_yukle_kaydet_birimi;
    logic       clk;
    logic       rst;
    logic [1:0] durum;

    yukle_kaydet_birimi_if yk();

    yukle_kaydet_birimi dut (
        .clk     (clk),
        .rst     (rst),
        .yk      (yk.slave),
        .o_durum (durum)
    );

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;
    int cyc            = 0;

    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [63:0] exp_yaz_q[$];

    logic [7:0]  ref_mem [0:63];
    logic [31:0] mem     [0:15];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: gozlenen=timeout beklenen=finish");
        hata_sayisi++;
        $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
        $finish;
    end

    // ---------------- checking ----------------
    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gozlenen=0x%0h beklenen=0x%0h (cyc %0d)", etiket, gozlenen, beklenen, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] baslangic(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_kelime(input logic [31:0] a);
        int b;
        b = int'(a[5:0]) / 4 * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic bit ref_yasal(input bit yaz, input logic [2:0] f3, input logic [31:0] a);
        bit f3_ok;
        bit hizali;
        int ai;
        ai     = int'(a[5:0]);
        f3_ok  = yaz ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        hizali = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) hizali = (ai % 2 == 0);
        if (f3 == 3'd2)               hizali = (ai % 4 == 0);
        return f3_ok && hizali;
    endfunction

    function automatic logic [31:0] ref_yukle(input logic [2:0] f3, input logic [31:0] a);
        int b;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] s;
        b = int'(a[5:0]);
        case (f3)
            3'd0: begin sb = ref_mem[b]; s = sb; return s; end
            3'd4: return {24'h0, ref_mem[b]};
            3'd1: begin sh = {ref_mem[b+1], ref_mem[b]}; s = sh; return s; end
            3'd5: return {16'h0, ref_mem[b+1], ref_mem[b]};
            default: return ref_kelime(a);
        endcase
    endfunction

    task automatic ref_yaz(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
        int b;
        int n;
        b = int'(a[5:0]);
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[b+k] = v[8*k +: 8];
    endtask

    // ---------------- memory stand-in (falling-edge word memory) ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = baslangic(i);
        yk.bellek_oku_veri = 32'h0;
        forever begin
            @(negedge clk);
            if (yk.bellek_oku_aktif) yk.bellek_oku_veri = mem[yk.bellek_adres[5:2]];
            if (yk.bellek_yaz_aktif) mem[yk.bellek_adres[5:2]] = yk.bellek_yaz_veri;
        end
    end

    // ---------------- driver ----------------
    task automatic istek_gonder(input bit yaz, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] v, input bit tut, input bit kayit, output int e0);
        int bekle;
        bekle = 0;
        @(negedge clk);
        yk.istek_gecerli = 1'b1;
        yk.istek_yaz     = yaz;
        yk.funct3        = f3;
        yk.adres         = a;
        yk.kaydet_veri   = v;
        while (!yk.istek_hazir && bekle < 50) begin
            @(negedge clk);
            bekle++;
        end
        if (!yk.istek_hazir) begin
            kontrol("kabul_zaman_asimi", 64'd0, 64'd1);
            yk.istek_gecerli = 1'b0;
            e0 = -1;
            return;
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        if (!tut) yk.istek_gecerli = 1'b0;
        if (kayit) begin
            if (!ref_yasal(yaz, f3, a)) begin
                exp_q.push_back({1'b1, 32'h0});
                exp_cyc_q.push_back(e0);
            end else if (!yaz) begin
                exp_q.push_back({1'b0, ref_yukle(f3, a)});
                exp_cyc_q.push_back(e0 + 1);
            end else begin
                ref_yaz(f3, a, v);
                exp_yaz_q.push_back({a[31:2], 2'b00, ref_kelime(a)});
                exp_q.push_back({1'b0, 32'h0});
                exp_cyc_q.push_back(e0 + ((f3 == 3'd2) ? 1 : 2));
            end
        end
    endtask

    task automatic bosalt();
        int bekle;
        bekle = 0;
        while (exp_q.size() != 0 && bekle < 50) begin
            @(negedge clk);
            bekle++;
        end
        @(negedge clk);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [32:0] e;
        logic [63:0] w;
        int c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                kontrol("strobe_cakisma", 64'(yk.bellek_oku_aktif & yk.bellek_yaz_aktif), 64'd0);
                if (yk.istek_hazir)
                    kontrol("bosta_strobe", 64'(yk.bellek_oku_aktif | yk.bellek_yaz_aktif), 64'd0);
                if (yk.bellek_yaz_aktif) begin
                    if (exp_yaz_q.size() == 0) begin
                        kontrol("beklenmedik_yazma", 64'd1, 64'd0);
                    end else begin
                        w = exp_yaz_q.pop_front();
                        kontrol("yazma_adres", 64'(yk.bellek_adres), 64'(w[63:32]));
                        kontrol("yazma_veri", 64'(yk.bellek_yaz_veri), 64'(w[31:0]));
                    end
                end
                if (yk.sonuc_gecerli) begin
                    if (exp_q.size() == 0) begin
                        kontrol("beklenmedik_sonuc", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        c = exp_cyc_q.pop_front();
                        kontrol("sonuc_veri", 64'(yk.sonuc_veri), 64'(e[31:0]));
                        kontrol("hizasiz_hata", 64'(yk.hizasiz_hata), 64'(e[32]));
                        kontrol("sonuc_gecikme", 64'(cyc), 64'(c));
                    end
                end else begin
                    kontrol("hata_darbesi", 64'(yk.hizasiz_hata), 64'd0);
                    if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
                        kontrol("sonuc_zaman_asimi", 64'd0, 64'd1);
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int e;
        int e_sb;
        int e_lw;
        logic [31:0] w0;
        rst              = 1'b1;
        yk.istek_gecerli = 1'b0;
        yk.istek_yaz     = 1'b0;
        yk.funct3        = 3'd0;
        yk.adres         = 32'h0;
        yk.kaydet_veri   = 32'h0;
        for (int i = 0; i < 64; i++) begin
            w0 = baslangic(i / 4);
            ref_mem[i] = w0[8*(i%4) +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        kontrol("reset_hazir", 64'(yk.istek_hazir), 64'd1);
        kontrol("reset_durum", 64'(durum), 64'd0);
        kontrol("reset_sonuc_gecerli", 64'(yk.sonuc_gecerli), 64'd0);
        kontrol("reset_sonuc_veri", 64'(yk.sonuc_veri), 64'd0);
        kontrol("reset_hata", 64'(yk.hizasiz_hata), 64'd0);
        kontrol("reset_strobe", 64'({yk.bellek_oku_aktif, yk.bellek_yaz_aktif}), 64'd0);
        kontrol("reset_bellek_adres", 64'(yk.bellek_adres), 64'd0);
        kontrol("reset_yaz_veri", 64'(yk.bellek_yaz_veri), 64'd0);

        // SW then LW
        istek_gonder(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, e);
        // SB into top lane, signed and unsigned byte loads
        istek_gonder(1'b1, 3'd0, 32'h13, 32'h0000_55AA, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 1'b1, e);
        // SH upper half, halfword loads
        istek_gonder(1'b1, 3'd1, 32'h12, 32'h0000_1234, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd5, 32'h10, 32'h0, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 1'b1, e);
        // illegal requests, then the word is still intact
        istek_gonder(1'b0, 3'd2, 32'h11, 32'h0, 1'b0, 1'b1, e);
        istek_gonder(1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, 1'b1, e);
        istek_gonder(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, e);
        // back-to-back: LW accepted in the SB completion cycle
        istek_gonder(1'b1, 3'd0, 32'h21, 32'h0000_00C3, 1'b1, 1'b1, e_sb);
        istek_gonder(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, e_lw);
        kontrol("ardisik_kabul", 64'(e_lw), 64'(e_sb + 3));
        bosalt();

        // reset lands on the RMW_OKU -> YAZ edge: the write must not happen
        istek_gonder(1'b1, 3'd0, 32'h10, 32'h0000_00FF, 1'b0, 1'b0, e);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        kontrol("abort_hazir", 64'(yk.istek_hazir), 64'd1);
        kontrol("abort_strobe", 64'({yk.bellek_oku_aktif, yk.bellek_yaz_aktif}), 64'd0);
        kontrol("abort_sonuc", 64'({yk.sonuc_gecerli, yk.hizasiz_hata}), 64'd0);
        kontrol("abort_bellek_adres", 64'(yk.bellek_adres), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        istek_gonder(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, e);
        bosalt();

        // random traffic, with and without idle gaps
        for (int n = 0; n < 400; n++) begin
            bit          yaz;
            bit          bosluk;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] v;
            yaz    = 1'($urandom_range(0, 1));
            f3     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if (!yaz && $urandom_range(0, 2) == 0) f3 = 3'($urandom_range(4, 5));
            a      = 32'($urandom_range(0, 63));
            v      = $urandom;
            bosluk = ($urandom_range(0, 3) == 0) || (n == 399);
            istek_gonder(yaz, f3, a, v, !bosluk, 1'b1, e);
            if (bosluk) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bosalt();

        kontrol("kalan_sonuc", 64'(exp_q.size()), 64'd0);
        kontrol("kalan_yazma", 64'(exp_yaz_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
        $finish;
    end
endmodule
